alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked sequential ALU. It extends the lab's combinational 4-bit ALU to a configurable width and adds iterative shift and multiply operations. Operands are captured on a valid/ready input handshake. Results and flags are held on a valid/ready output handshake until the consumer takes them. It sits between the operand source (switches or register file) and the result consumer (display driver or writeback).

## Interface
- `W`, default 4: datapath width; power of two, 4..32.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand/op request.
- `in_ready` output 1: block can accept a request; equals state==IDLE.
- `a` input W: operand A.
- `b` input W: operand B (shift amount for shifts).
- `op` input 4: operation select.
- `out_valid` output 1: result valid; equals state==DONE.
- `out_ready` input 1: consumer accepts the result.
- `res` output W: result.
- `car` output 1: carry / shifted-out bit / multiply high-nonzero.
- `of` output 1: signed overflow.
- `zf` output 1: res==0.
- `err` output 1: illegal op code.

## Operation
- **Ops:**
  - 0 add.
  - 1 sub.
  - 2 not a.
  - 3 and.
  - 4 or.
  - 5 xor.
  - 6 slt (signed a<b).
  - 7 eq.
  - 8 sll.
  - 9 srl.
  - 10 sra.
  - 11 mul (unsigned, low W bits).
  - 12–15 illegal.
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE:**
  - On in_valid&&in_ready, latch a, b, op into internal registers.
  - Ops 0–7, 12–15, and shifts with shamt==0 go to DONE.
  - Shifts with shamt!=0 and mul go to EXEC.
- **EXEC:**
  - Shifts move one bit per cycle; the shift counter loads shamt = b[log2(W)-1:0].
  - Mul is shift-add over exactly W cycles.
  - Go to DONE when the counter expires.
- **DONE:**
  - res/car/of/zf/err are held stable.
  - On out_ready, go to IDLE.
  - No request is accepted in the same cycle, because in_ready is 0 in DONE.
- **Operand capture:** only the captured operands are used. Changes on a/b/op after acceptance have no effect.
- **Arithmetic and flags:**
  - add: {car,res}=a+b. of=(a[W-1]==b[W-1])&&(res[W-1]!=a[W-1]).
  - sub: {car,res}=a+~b+1, so car=1 means no borrow. of=(a[W-1]!=b[W-1])&&(res[W-1]!=a[W-1]).
  - not/and/or/xor: car=0, of=0.
  - slt: res={W-1 zeros, signed(a)<signed(b)}. car=of=0.
  - eq: res={W-1 zeros, a==b}. car=of=0.
  - sll/srl/sra: car=last bit shifted out, 0 if shamt==0. of=0. sra replicates a[W-1].
  - mul: res=low W bits of a*b. car=1 if high W bits != 0. of=0.
  - Illegal ops: res=0, car=of=0, zf=1, err=1. For all legal ops err=0.
  - zf=(res==0) for every op.
- **Reset:** asserting rst_n mid-operation aborts the operation, goes to IDLE, and never produces a result for the aborted request.

## Timing
- **Reset values:**
  - state=IDLE, so in_ready=1 and out_valid=0.
  - res=0, car=0, of=0, zf=0, err=0.
  - Internal counters and operand registers are 0.
  - Inputs are ignored while rst_n=0.
- **Latency, from the accept edge to out_valid=1:**
  - 1 cycle for ops 0–7, 12–15, and shifts with shamt==0.
  - 1+shamt cycles for shifts.
  - W+1 cycles for mul.
- **Output registers:** res and flags update only on entry to DONE. Between results they keep the last delivered value.
- **Throughput:** one request at a time. With out_ready held at 1, the minimum issue interval is latency+1 cycles.
- **Back-pressure:** out_valid stays 1 and outputs stay stable for any number of cycles while out_ready=0.
- **Input with in_ready=0:** in_valid asserted while in_ready=0 is ignored; it is neither queued nor lost silently once the source holds it.

## Test plan
1. Reset, then W=4, op=0, a=7, b=1, in_valid for 1 cycle → 1 cycle later: out_valid=1, res=8, of=1, car=0, zf=0.
2. op=1, a=0, b=1 → res=4'hF, car=0, of=0. op=1, a=8, b=1 → res=7, of=1, car=1.
3. op=8, a=4'b1011, b=3 → out_valid 4 cycles after accept, res=4'b1000, car=1. op=10, a=4'b1000, b=2 → res=4'b1110, car=0. op=9, b=0 → latency 1, car=0.
4. op=11, a=5, b=3 → res=15, car=0, latency 5. op=11, a=6, b=3 → res=2, car=1.
5. After op=6, a=4'hF (-1), b=1: hold out_ready=0 for 3 cycles while pulsing in_valid with new operands → out_valid stays 1, res=1 stays unchanged, in_ready=0, no second result. Then out_ready=1 → IDLE next cycle.
6. Start mul, assert rst_n=0 at cycle 2 of EXEC → immediately in_ready=1, out_valid=0, all outputs 0. op=4'hC → res=0, err=1, zf=1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arithmetic ops plus iterative
// shifts (one bit per cycle) and a W-cycle shift-add multiplier.
module alu_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         car,
  output logic         of,
  output logic         zf,
  output logic         err
);
  localparam int LW = $clog2(W);
  localparam logic [W:0]  ONE_W1  = (W+1)'(1);
  localparam logic [LW:0] CNT_ONE = (LW+1)'(1);
  localparam logic [LW:0] CNT_MUL = (LW+1)'(W);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state;
  logic [3:0]      op_reg;
  logic [W-1:0]    data_reg;   // shift data, or the multiplier for mul
  logic [2*W-1:0]  mc_reg;     // multiplicand, shifted left each mul step
  logic [2*W-1:0]  acc_reg;
  logic [LW:0]     cnt_reg;

  logic [LW-1:0]   shamt;
  logic            is_shift;
  logic [W:0]      sum, diff;
  logic [W-1:0]    alu_res;
  logic            alu_car, alu_of, alu_err;
  logic [W-1:0]    sh_next;
  logic            sh_out;
  logic [2*W-1:0]  acc_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shamt     = b[LW-1:0];
  assign is_shift  = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} + {1'b0, ~b} + ONE_W1;
  assign acc_next  = acc_reg + (data_reg[0] ? mc_reg : '0);

  // Single-cycle results, computed from the operands at the accept edge.
  always_comb begin
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    case (op)
      4'd0: begin
        {alu_car, alu_res} = sum;
        alu_of = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      4'd1: begin
        {alu_car, alu_res} = diff;
        alu_of = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      4'd2:  alu_res = ~a;
      4'd3:  alu_res = a & b;
      4'd4:  alu_res = a | b;
      4'd5:  alu_res = a ^ b;
      4'd6:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd7:  alu_res = {{(W-1){1'b0}}, (a == b)};
      4'd8, 4'd9, 4'd10: alu_res = a;   // zero shift amount
      4'd11: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    sh_next = data_reg;
    sh_out  = 1'b0;
    case (op_reg)
      4'd8:    begin sh_next = {data_reg[W-2:0], 1'b0};         sh_out = data_reg[W-1]; end
      4'd9:    begin sh_next = {1'b0, data_reg[W-1:1]};         sh_out = data_reg[0];   end
      4'd10:   begin sh_next = {data_reg[W-1], data_reg[W-1:1]}; sh_out = data_reg[0];  end
      default: begin sh_next = data_reg;                        sh_out = 1'b0;          end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_reg   <= '0;
      data_reg <= '0;
      mc_reg   <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      res      <= '0;
      car      <= 1'b0;
      of       <= 1'b0;
      zf       <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_reg   <= op;
            data_reg <= (op == 4'd11) ? b : a;
            mc_reg   <= {{W{1'b0}}, a};
            acc_reg  <= '0;
            if (is_shift && (shamt != '0)) begin
              cnt_reg <= {1'b0, shamt};
              state   <= EXEC;
            end else if (op == 4'd11) begin
              cnt_reg <= CNT_MUL;
              state   <= EXEC;
            end else begin
              res   <= alu_res;
              car   <= alu_car;
              of    <= alu_of;
              zf    <= (alu_res == '0);
              err   <= alu_err;
              state <= DONE;
            end
          end
        end
        EXEC: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (op_reg == 4'd11) begin
            acc_reg  <= acc_next;
            mc_reg   <= mc_reg << 1;
            data_reg <= data_reg >> 1;
          end else begin
            data_reg <= sh_next;
          end
          // Last step: publish the result straight from this cycle's step.
          if (cnt_reg == CNT_ONE) begin
            state <= DONE;
            of    <= 1'b0;
            err   <= 1'b0;
            if (op_reg == 4'd11) begin
              res <= acc_next[W-1:0];
              car <= |acc_next[2*W-1:W];
              zf  <= (acc_next[W-1:0] == '0);
            end else begin
              res <= sh_next;
              car <= sh_out;
              zf  <= (sh_next == '0);
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=4): directed table, random ops against an
// arithmetic reference model, back-pressure and mid-operation reset sequences.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0, b = '0, op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] res;
  logic       car, of, zf, err;

  int checks = 0;
  int errors = 0;

  alu_seq #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .car(car), .of(of), .zf(zf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op, a, b;
    int res, car, of, zf, err, lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the ALU rules.
  function automatic vec_t model(input int op_i, input int a_i, input int b_i);
    vec_t v;
    int s, sa, sb, p;
    s  = b_i & 3;
    sa = (a_i >= 8) ? a_i - 16 : a_i;
    sb = (b_i >= 8) ? b_i - 16 : b_i;
    v.op = op_i; v.a = a_i; v.b = b_i;
    v.res = 0; v.car = 0; v.of = 0; v.err = 0; v.lat = 1;
    case (op_i)
      0: begin v.res = (a_i + b_i) & 15; v.car = (a_i + b_i > 15) ? 1 : 0;
               v.of = (sa + sb > 7 || sa + sb < -8) ? 1 : 0; end
      1: begin v.res = (a_i - b_i) & 15; v.car = (a_i >= b_i) ? 1 : 0;
               v.of = (sa - sb > 7 || sa - sb < -8) ? 1 : 0; end
      2: v.res = (~a_i) & 15;
      3: v.res = a_i & b_i;
      4: v.res = a_i | b_i;
      5: v.res = a_i ^ b_i;
      6: v.res = (sa < sb) ? 1 : 0;
      7: v.res = (a_i == b_i) ? 1 : 0;
      8: begin v.res = (a_i << s) & 15; v.car = (s != 0) ? (a_i >> (4 - s)) & 1 : 0; v.lat = 1 + s; end
      9: begin v.res = a_i >> s; v.car = (s != 0) ? (a_i >> (s - 1)) & 1 : 0; v.lat = 1 + s; end
      10: begin v.res = (sa >>> s) & 15; v.car = (s != 0) ? (sa >>> (s - 1)) & 1 : 0; v.lat = 1 + s; end
      11: begin p = a_i * b_i; v.res = p & 15; v.car = (p > 15) ? 1 : 0; v.lat = 5; end
      default: v.err = 1;
    endcase
    v.zf = (v.res == 0) ? 1 : 0;
    return v;
  endfunction

  // One full request/response; scrambles inputs right after acceptance.
  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1; op = v.op[3:0]; a = v.a[3:0]; b = v.b[3:0];
    @(posedge clk); #1;
    in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("txn %s op=%0d a=%0d b=%0d -> res=%0d car=%0d of=%0d zf=%0d err=%0d lat=%0d",
             tag, v.op, v.a, v.b, res, car, of, zf, err, lat);
    chk({tag, " lat"}, lat, v.lat);
    chk({tag, " res"}, int'(res), v.res);
    chk({tag, " car"}, int'(car), v.car);
    chk({tag, " of"},  int'(of),  v.of);
    chk({tag, " zf"},  int'(zf),  v.zf);
    chk({tag, " err"}, int'(err), v.err);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle out_valid"}, int'(out_valid), 0);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = '{0, 7, 1, 8, 0, 1, 0, 0, 1};
    tbl[1]  = '{1, 0, 1, 15, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 8, 1, 7, 1, 1, 0, 0, 1};
    tbl[3]  = '{8, 11, 3, 8, 1, 0, 0, 0, 4};
    tbl[4]  = '{10, 8, 2, 14, 0, 0, 0, 0, 3};
    tbl[5]  = '{9, 5, 0, 5, 0, 0, 0, 0, 1};
    tbl[6]  = '{11, 5, 3, 15, 0, 0, 0, 0, 5};
    tbl[7]  = '{11, 6, 3, 2, 1, 0, 0, 0, 5};
    tbl[8]  = '{12, 3, 4, 0, 0, 0, 1, 1, 1};
    tbl[9]  = '{7, 6, 6, 1, 0, 0, 0, 0, 1};
    tbl[10] = '{2, 5, 0, 10, 0, 0, 0, 0, 1};
    tbl[11] = '{8, 3, 5, 6, 0, 0, 0, 0, 2};

    // Reset state
    #12;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst res", int'(res), 0);
    chk("rst flags", int'({car, of, zf, err}), 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 60; i++) begin
      rv = model($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Back-pressure: result held, new requests ignored while DONE.
    begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd6; a = 4'hF; b = 4'd1;
      @(posedge clk); #1;
      chk("bp first valid", int'(out_valid), 1);
      chk("bp first res", int'(res), 1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); in_valid = 1'b1; op = 4'd0; a = 4'd3; b = 4'd3;
        @(posedge clk); #1;
        $display("txn bp hold%0d out_valid=%0d in_ready=%0d res=%0d", k, out_valid, in_ready, res);
        chk("bp hold out_valid", int'(out_valid), 1);
        chk("bp hold in_ready", int'(in_ready), 0);
        chk("bp hold res", int'(res), 1);
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release out_valid", int'(out_valid), 0);
      chk("bp release in_ready", int'(in_ready), 1);
      repeat (3) @(posedge clk);
      #1 chk("bp no second result", int'(out_valid), 0);
    end

    // Reset in the middle of a multiply.
    begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd11; a = 4'd5; b = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      $display("txn reset-abort in_ready=%0d out_valid=%0d res=%0d", in_ready, out_valid, res);
      chk("abort in_ready", int'(in_ready), 1);
      chk("abort out_valid", int'(out_valid), 0);
      chk("abort res", int'(res), 0);
      chk("abort flags", int'({car, of, zf, err}), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("abort no result", int'(out_valid), 0);
      rv = model(12, 0, 0);
      run_txn(rv, "illegal_after_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
